alu_issue_ctrl: RTL and testbench

//  Decode/issue/writeback stage feeding the 32-bit alu (scr1/scr2/opcode/sub_opcode/enable_execute/reset).

---
 rtl/alu_issue_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// Decode/issue/writeback controller for the 32-bit ALU: one instruction per
// four cycles, with a 32x32 register file, a preload port and a debug read port.
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | ready for an instruction; preload writes are accepted
// DECODE | decode latched instruction, register ALU operands
// EXEC   | ALU out of reset and enabled; result sampled at the end
// WB     | result written to rt, done pulse
module alu_issue_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic        ext_we,
    input  logic [4:0]  ext_waddr,
    input  logic [31:0] ext_wdata,
    input  logic [4:0]  dbg_addr,
    output logic [31:0] dbg_data,
    output logic [31:0] scr1,
    output logic [31:0] scr2,
    output logic [5:0]  opcode,
    output logic [4:0]  sub_opcode,
    output logic        enable_execute,
    output logic        alu_reset,
    input  logic [31:0] alu_result,
    input  logic        alu_overflow,
    output logic        done,
    output logic        overflow,
    output logic        illegal
);

    localparam logic [5:0] OP_ARITH  = 6'b100000;
    localparam logic [5:0] OP_ADDI   = 6'b101000;
    localparam logic [5:0] OP_ORI    = 6'b101100;
    localparam logic [5:0] OP_XORI   = 6'b101011;
    localparam logic [5:0] OP_MOVI   = 6'b100010;

    localparam logic [4:0] SUB_ADD   = 5'b00000;
    localparam logic [4:0] SUB_SUB   = 5'b00001;
    localparam logic [4:0] SUB_AND   = 5'b00010;
    localparam logic [4:0] SUB_XOR   = 5'b00011;
    localparam logic [4:0] SUB_OR    = 5'b00100;
    localparam logic [4:0] SUB_SLLI  = 5'b01000;
    localparam logic [4:0] SUB_SRLI  = 5'b01001;
    localparam logic [4:0] SUB_ROTRI = 5'b01011;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DECODE = 2'd1,
        S_EXEC   = 2'd2,
        S_WB     = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [31:0] instr_q;
    logic [31:0] result_q;
    logic        is_movi_q;
    logic [31:0] regs [32];

    logic [5:0]  dec_op;
    logic [4:0]  dec_rt;
    logic [4:0]  dec_ra;
    logic [4:0]  dec_rb;
    logic [4:0]  dec_sub;
    logic [14:0] dec_imm15;
    logic [19:0] dec_imm20;
    logic        dec_legal;
    logic        dec_movi;
    logic [31:0] dec_scr2;
    logic        unused_instr_bit;

    assign dec_op    = instr_q[30:25];
    assign dec_rt    = instr_q[24:20];
    assign dec_ra    = instr_q[19:15];
    assign dec_rb    = instr_q[14:10];
    assign dec_sub   = instr_q[4:0];
    assign dec_imm15 = instr_q[14:0];
    assign dec_imm20 = instr_q[19:0];
    assign unused_instr_bit = instr_q[31];

    assign dbg_data  = regs[dbg_addr];

    always_comb begin
        dec_legal = 1'b0;
        dec_movi  = 1'b0;
        dec_scr2  = '0;
        case (dec_op)
            OP_ARITH: begin
                case (dec_sub)
                    SUB_SLLI, SUB_SRLI, SUB_ROTRI: begin
                        dec_legal = 1'b1;
                        dec_scr2  = {27'b0, dec_rb};
                    end
                    SUB_ADD, SUB_SUB, SUB_AND, SUB_XOR, SUB_OR: begin
                        dec_legal = 1'b1;
                        dec_scr2  = regs[dec_rb];
                    end
                    default: ;
                endcase
            end
            OP_ADDI: begin
                dec_legal = 1'b1;
                dec_scr2  = {{17{dec_imm15[14]}}, dec_imm15};
            end
            OP_ORI, OP_XORI: begin
                dec_legal = 1'b1;
                dec_scr2  = {17'b0, dec_imm15};
            end
            OP_MOVI: begin
                dec_legal = 1'b1;
                dec_movi  = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        instr_ready    = 1'b0;
        enable_execute = 1'b0;
        alu_reset      = 1'b1;
        done           = 1'b0;
        illegal        = 1'b0;
        case (state)
            S_IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    state_nxt = S_DECODE;
                end
            end
            S_DECODE: begin
                illegal   = ~dec_legal;
                state_nxt = dec_legal ? S_EXEC : S_IDLE;
            end
            S_EXEC: begin
                // MOVI keeps the ALU parked; it only borrows the slot for uniform timing
                enable_execute = ~is_movi_q;
                alu_reset      = is_movi_q;
                state_nxt      = S_WB;
            end
            S_WB: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            instr_q    <= '0;
            result_q   <= '0;
            is_movi_q  <= 1'b0;
            scr1       <= '0;
            scr2       <= '0;
            opcode     <= '0;
            sub_opcode <= '0;
            overflow   <= 1'b0;
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (instr_valid) begin
                        instr_q <= instr;
                    end
                    if (ext_we) begin
                        regs[ext_waddr] <= ext_wdata;
                    end
                end
                S_DECODE: begin
                    if (dec_legal) begin
                        is_movi_q <= dec_movi;
                        if (dec_movi) begin
                            result_q <= {{12{dec_imm20[19]}}, dec_imm20};
                        end else begin
                            scr1       <= regs[dec_ra];
                            scr2       <= dec_scr2;
                            opcode     <= dec_op;
                            sub_opcode <= dec_sub;
                        end
                    end
                end
                S_EXEC: begin
                    if (is_movi_q) begin
                        overflow <= 1'b0;
                    end else begin
                        result_q <= alu_result;
                        overflow <= alu_overflow;
                    end
                end
                S_WB: begin
                    regs[dec_rt] <= result_q;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl: a behavioural ALU sits on the operand
// outputs, directed instructions push expected writebacks, a monitor checks them.
module tb_alu_issue_ctrl;

    localparam logic [5:0] OP_ARITH = 6'b100000;
    localparam logic [5:0] OP_ADDI  = 6'b101000;
    localparam logic [5:0] OP_ORI   = 6'b101100;
    localparam logic [5:0] OP_XORI  = 6'b101011;
    localparam logic [5:0] OP_MOVI  = 6'b100010;

    logic        clk;
    logic        reset;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic        ext_we;
    logic [4:0]  ext_waddr;
    logic [31:0] ext_wdata;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_data;
    logic [31:0] scr1;
    logic [31:0] scr2;
    logic [5:0]  opcode;
    logic [4:0]  sub_opcode;
    logic        enable_execute;
    logic        alu_reset;
    logic [31:0] alu_result;
    logic        alu_overflow;
    logic        done;
    logic        overflow;
    logic        illegal;

    logic [4:0]  stim_addr;
    logic [4:0]  mon_addr;
    logic        mon_busy;
    assign dbg_addr = mon_busy ? mon_addr : stim_addr;

    int errors = 0;
    int checks = 0;
    int ee_count = 0;
    int ill_count = 0;

    typedef struct {
        logic [4:0]  rt;
        logic [31:0] value;
        logic        ovf;
        string       name;
    } exp_t;
    exp_t sb[$];

    alu_issue_ctrl dut (
        .clk(clk), .reset(reset), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .ext_we(ext_we), .ext_waddr(ext_waddr),
        .ext_wdata(ext_wdata), .dbg_addr(dbg_addr), .dbg_data(dbg_data),
        .scr1(scr1), .scr2(scr2), .opcode(opcode), .sub_opcode(sub_opcode),
        .enable_execute(enable_execute), .alu_reset(alu_reset),
        .alu_result(alu_result), .alu_overflow(alu_overflow), .done(done),
        .overflow(overflow), .illegal(illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU driven by the DUT's registered operands
    always_comb begin
        logic [31:0] sum;
        int          sh;
        alu_result   = '0;
        alu_overflow = 1'b0;
        sum          = scr1 + scr2;
        sh           = int'(scr2[4:0]);
        case (opcode)
            OP_ARITH: begin
                case (sub_opcode)
                    5'b00000: begin
                        alu_result   = sum;
                        alu_overflow = (scr1[31] == scr2[31]) && (sum[31] != scr1[31]);
                    end
                    5'b00001: alu_result = scr1 - scr2;
                    5'b00010: alu_result = scr1 & scr2;
                    5'b00011: alu_result = scr1 ^ scr2;
                    5'b00100: alu_result = scr1 | scr2;
                    5'b01000: alu_result = scr1 << sh;
                    5'b01001: alu_result = scr1 >> sh;
                    5'b01011: alu_result = (scr1 >> sh) | ((sh == 0) ? 32'h0 : (scr1 << (32 - sh)));
                    default:  alu_result = 32'hBAD0_BAD0;
                endcase
            end
            OP_ADDI: begin
                alu_result   = sum;
                alu_overflow = (scr1[31] == scr2[31]) && (sum[31] != scr1[31]);
            end
            OP_ORI:  alu_result = scr1 | scr2;
            OP_XORI: alu_result = scr1 ^ scr2;
            default: alu_result = 32'hBAD1_BAD1;
        endcase
    end

    always @(negedge clk) begin
        if (enable_execute === 1'b1) ee_count++;
        if (illegal === 1'b1) ill_count++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse pops one expectation; value is checked once written
    initial begin
        exp_t e;
        mon_busy = 1'b0;
        mon_addr = '0;
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done=1 expected no writeback");
                end else begin
                    e = sb.pop_front();
                    check({e.name, "_ovf"}, {31'b0, overflow}, {31'b0, e.ovf});
                    mon_addr = e.rt;
                    mon_busy = 1'b1;
                    @(negedge clk);
                    check(e.name, dbg_data, e.value);
                    mon_busy = 1'b0;
                end
            end
        end
    end

    function automatic logic [31:0] enc_r(input logic [5:0] op, input logic [4:0] rt,
                                          input logic [4:0] ra, input logic [4:0] rb,
                                          input logic [4:0] sub);
        return {1'b0, op, rt, ra, rb, 5'b0, sub};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rt,
                                          input logic [4:0] ra, input logic [14:0] imm);
        return {1'b0, op, rt, ra, imm};
    endfunction

    // All tasks below start and end on a falling edge
    task automatic wait_ready();
        int n = 0;
        while (instr_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: got instr_ready=%b expected 1", instr_ready);
        end
    endtask

    task automatic issue(input logic [31:0] w);
        wait_ready();
        instr       = w;
        instr_valid = 1'b1;
        @(posedge clk);
        #1 instr_valid = 1'b0;
    endtask

    task automatic preload(input logic [4:0] a, input logic [31:0] d);
        ext_we    = 1'b1;
        ext_waddr = a;
        ext_wdata = d;
        @(posedge clk);
        #1 ext_we = 1'b0;
        @(negedge clk);
    endtask

    task automatic read_reg(input string name, input logic [4:0] a, input logic [31:0] exp);
        stim_addr = a;
        #1 check(name, dbg_data, exp);
    endtask

    task automatic run(input string name, input logic [31:0] w, input logic [4:0] rt,
                       input logic [31:0] val, input logic ovf,
                       input logic chk_scr2, input logic [31:0] scr2_exp);
        exp_t e;
        e.rt = rt; e.value = val; e.ovf = ovf; e.name = name;
        sb.push_back(e);
        issue(w);
        @(negedge clk);
        @(negedge clk);
        if (chk_scr2) check({name, "_scr2"}, scr2, scr2_exp);
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0;
        int i0;
        reset       = 1'b1;
        instr       = '0;
        instr_valid = 1'b0;
        ext_we      = 1'b0;
        ext_waddr   = '0;
        ext_wdata   = '0;
        stim_addr   = 5'd5;
        repeat (2) @(negedge clk);
        check("rst_ready", {31'b0, instr_ready}, 32'd1);
        check("rst_alu_reset", {31'b0, alu_reset}, 32'd1);
        check("rst_enable", {31'b0, enable_execute}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_flags", {30'b0, overflow, illegal}, 32'd0);
        check("rst_scr1", scr1, 32'd0);
        check("rst_scr2", scr2, 32'd0);
        check("rst_ops", {21'b0, opcode, sub_opcode}, 32'd0);
        check("rst_reg5", dbg_data, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        preload(5'd1, 32'h0000_162E);
        preload(5'd2, 32'h0000_04D2);

        // ADD with cycle-by-cycle handshake checks
        begin
            exp_t e;
            e.rt = 5'd3; e.value = 32'h0000_1B00; e.ovf = 1'b0; e.name = "add";
            sb.push_back(e);
            issue(enc_r(OP_ARITH, 5'd3, 5'd1, 5'd2, 5'b00000));
            @(negedge clk);
            check("dec_ready", {31'b0, instr_ready}, 32'd0);
            check("dec_enable", {31'b0, enable_execute}, 32'd0);
            check("dec_alu_reset", {31'b0, alu_reset}, 32'd1);
            @(negedge clk);
            check("exec_enable", {31'b0, enable_execute}, 32'd1);
            check("exec_alu_reset", {31'b0, alu_reset}, 32'd0);
            check("exec_scr1", scr1, 32'h0000_162E);
            check("exec_scr2", scr2, 32'h0000_04D2);
            check("exec_opcode", {26'b0, opcode}, {26'b0, OP_ARITH});
            @(negedge clk);
            check("wb_done", {31'b0, done}, 32'd1);
            check("wb_enable", {31'b0, enable_execute}, 32'd0);
            @(negedge clk);
            check("c4_ready", {31'b0, instr_ready}, 32'd1);
            check("c4_done", {31'b0, done}, 32'd0);
        end

        run("sub",   enc_r(OP_ARITH, 5'd3, 5'd1, 5'd2, 5'b00001), 5'd3, 32'h0000_115C, 1'b0, 1'b0, 32'd0);
        run("and",   enc_r(OP_ARITH, 5'd3, 5'd1, 5'd2, 5'b00010), 5'd3, 32'h0000_0402, 1'b0, 1'b0, 32'd0);
        run("or",    enc_r(OP_ARITH, 5'd3, 5'd1, 5'd2, 5'b00100), 5'd3, 32'h0000_16FE, 1'b0, 1'b0, 32'd0);
        run("xor",   enc_r(OP_ARITH, 5'd3, 5'd1, 5'd2, 5'b00011), 5'd3, 32'h0000_12FC, 1'b0, 1'b0, 32'd0);
        run("srli",  enc_r(OP_ARITH, 5'd4, 5'd1, 5'd3, 5'b01001), 5'd4, 32'h0000_02C5, 1'b0, 1'b1, 32'd3);
        run("slli",  enc_r(OP_ARITH, 5'd4, 5'd1, 5'd3, 5'b01000), 5'd4, 32'h0000_B170, 1'b0, 1'b1, 32'd3);
        run("rotri", enc_r(OP_ARITH, 5'd4, 5'd1, 5'd3, 5'b01011), 5'd4, 32'hC000_02C5, 1'b0, 1'b1, 32'd3);
        run("addi",  enc_i(OP_ADDI, 5'd5, 5'd1, 15'h7F9C), 5'd5, 32'h0000_15CA, 1'b0, 1'b1, 32'hFFFF_FF9C);
        run("ori",   enc_i(OP_ORI,  5'd6, 5'd1, 15'h00F0), 5'd6, 32'h0000_16FE, 1'b0, 1'b0, 32'd0);
        run("ori_zext", enc_i(OP_ORI, 5'd15, 5'd1, 15'h4000), 5'd15, 32'h0000_562E, 1'b0, 1'b1, 32'h0000_4000);

        // ext_we held high through DECODE/EXEC/WB must not reach the regfile
        ext_waddr = 5'd20;
        ext_wdata = 32'hDEAD_BEEF;
        begin
            exp_t e;
            e.rt = 5'd6; e.value = 32'h0000_16DE; e.ovf = 1'b0; e.name = "xori";
            sb.push_back(e);
            issue(enc_i(OP_XORI, 5'd6, 5'd1, 15'h00F0));
            ext_we = 1'b1;
            repeat (3) @(negedge clk);
            ext_we = 1'b0;
            @(negedge clk);
        end
        read_reg("busy_ext_we", 5'd20, 32'd0);

        e0 = ee_count;
        run("movi", {1'b0, OP_MOVI, 5'd7, 20'h80000}, 5'd7, 32'hFFF8_0000, 1'b0, 1'b0, 32'd0);
        check("movi_no_enable", ee_count, e0);

        // Illegal opcode and illegal sub-op both target r3
        for (int k = 0; k < 2; k++) begin
            e0 = ee_count;
            i0 = ill_count;
            issue(k == 0 ? enc_r(6'b111111, 5'd3, 5'd1, 5'd2, 5'b00000)
                         : enc_r(OP_ARITH, 5'd3, 5'd1, 5'd2, 5'b00111));
            @(negedge clk);
            check("illegal_pulse", {31'b0, illegal}, 32'd1);
            @(negedge clk);
            check("illegal_back_idle", {31'b0, instr_ready}, 32'd1);
            check("illegal_one_cycle", {31'b0, illegal}, 32'd0);
            repeat (3) @(negedge clk);
            check("illegal_no_enable", ee_count, e0);
            check("illegal_count", ill_count, i0 + 1);
            read_reg("illegal_r3", 5'd3, 32'h0000_12FC);
        end

        // Preload and instruction accepted on the same edge; DECODE sees r11
        begin
            exp_t e;
            e.rt = 5'd12; e.value = 32'd6; e.ovf = 1'b0; e.name = "we_and_valid";
            sb.push_back(e);
            ext_we = 1'b1; ext_waddr = 5'd11; ext_wdata = 32'd5;
            instr = enc_i(OP_ADDI, 5'd12, 5'd11, 15'd1);
            instr_valid = 1'b1;
            @(posedge clk);
            #1 ext_we = 1'b0; instr_valid = 1'b0;
            repeat (4) @(negedge clk);
        end
        read_reg("preload_r11", 5'd11, 32'd5);

        preload(5'd8, 32'h7FFF_FFFF);
        preload(5'd9, 32'h0000_0001);
        run("add_ovf", enc_r(OP_ARITH, 5'd10, 5'd8, 5'd9, 5'b00000), 5'd10, 32'h8000_0000, 1'b1, 1'b0, 32'd0);
        run("hazard1", enc_r(OP_ARITH, 5'd13, 5'd1, 5'd2, 5'b00000), 5'd13, 32'h0000_1B00, 1'b0, 1'b0, 32'd0);
        run("hazard2", enc_r(OP_ARITH, 5'd14, 5'd13, 5'd1, 5'b00000), 5'd14, 32'h0000_312E, 1'b0, 1'b0, 32'd0);

        preload(5'd0, 32'h0000_0055);
        run("nop_r0", enc_r(OP_ARITH, 5'd0, 5'd0, 5'd0, 5'b01001), 5'd0, 32'h0000_0055, 1'b0, 1'b0, 32'd0);

        // Reset mid-EXEC: no done, no writeback; reset itself clears the regfile
        issue(enc_r(OP_ARITH, 5'd3, 5'd1, 5'd2, 5'b00000));
        @(negedge clk);
        @(negedge clk);
        check("abort_in_exec", {31'b0, enable_execute}, 32'd1);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("abort_ready", {31'b0, instr_ready}, 32'd1);
        check("abort_done", {31'b0, done}, 32'd0);
        check("abort_enable", {31'b0, enable_execute}, 32'd0);
        read_reg("abort_r3", 5'd3, 32'd0);
        repeat (4) @(negedge clk);
        check("scoreboard_empty", sb.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
